// File: rtl/mem1_stage_if.sv
// EXE->M1->M2 pipeline handshake, data-memory request channel and hazard/exception
// taps of the first memory stage, grouped for mem1_stage.
interface mem1_stage_if #(
   parameter int ES_TO_M1_BUS_WD = 175,
   parameter int M1_TO_M2_BUS_WD = 176
);
   logic                        es_to_m1s_valid;
   logic [ES_TO_M1_BUS_WD-1:0]  es_to_m1s_bus;
   logic                        m1s_allowin;
   logic                        m2s_allowin;
   logic                        m1s_to_m2s_valid;
   logic [M1_TO_M2_BUS_WD-1:0]  m1s_to_m2s_bus;
   logic                        flush;
   logic                        data_req;
   logic                        data_wr;
   logic [1:0]                  data_size;
   logic [31:0]                 data_addr;
   logic [3:0]                  data_wstrb;
   logic [31:0]                 data_wdata;
   logic                        data_addr_ok;
   logic                        m1s_discard;
   logic [4:0]                  M1_dest;
   logic [31:0]                 M1_result;
   logic                        m1s_load_op;
   logic                        m1s_inst_mfc0;
   logic                        m1s_ex;
   logic                        m1s_inst_eret;
   logic [31:0]                 m1s_stall_cnt;

   modport slave (
      input  es_to_m1s_valid, es_to_m1s_bus, m2s_allowin, flush, data_addr_ok,
      output m1s_allowin, m1s_to_m2s_valid, m1s_to_m2s_bus, data_req, data_wr,
             data_size, data_addr, data_wstrb, data_wdata, m1s_discard, M1_dest,
             M1_result, m1s_load_op, m1s_inst_mfc0, m1s_ex, m1s_inst_eret, m1s_stall_cnt
   );

   modport master (
      output es_to_m1s_valid, es_to_m1s_bus, m2s_allowin, flush, data_addr_ok,
      input  m1s_allowin, m1s_to_m2s_valid, m1s_to_m2s_bus, data_req, data_wr,
             data_size, data_addr, data_wstrb, data_wdata, m1s_discard, M1_dest,
             M1_result, m1s_load_op, m1s_inst_mfc0, m1s_ex, m1s_inst_eret, m1s_stall_cnt
   );
endinterface

// File: rtl/mem1_stage.sv
// First memory stage: registers the EXE bus and issues the data-memory address request.
// Optional stall counter enabled by defining M1_STALL_CNT_EN.
module mem1_stage #(
   parameter int ES_TO_M1_BUS_WD = 175,
   parameter int M1_TO_M2_BUS_WD = 176
) (
   input  logic         clk,
   input  logic         reset,
   mem1_stage_if.slave  m1_if
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACPT, S_DRAIN} state_t;

   state_t                      r_state;
   logic                        r_valid_p0;
   logic [ES_TO_M1_BUS_WD-1:0]  r_bus_p0;

   logic        w_load_op, w_mem_we, w_ex, w_mfc0, w_eret;
   logic [11:0] w_mem_inst;
   logic [31:0] w_alu_result;
   logic [4:0]  w_dest;
   logic        w_idle, w_wait, w_acpt, w_drain;
   logic        w_need_mem, w_req, w_ready_go, w_allowin, w_discard, w_hold_bus;
   logic        w_addr_ok, w_flush;

   assign w_load_op    = r_bus_p0[133];
   assign w_mem_we     = r_bus_p0[138];
   assign w_ex         = r_bus_p0[127];
   assign w_eret       = r_bus_p0[120];
   assign w_mfc0       = r_bus_p0[115];
   assign w_mem_inst   = r_bus_p0[82:71];
   assign w_dest       = r_bus_p0[68:64];
   assign w_alu_result = r_bus_p0[63:32];

   assign w_addr_ok = m1_if.data_addr_ok;
   assign w_flush   = m1_if.flush;

   assign w_idle  = (r_state == S_IDLE);
   assign w_wait  = (r_state == S_WAIT);
   assign w_acpt  = (r_state == S_ACPT);
   assign w_drain = (r_state == S_DRAIN);

   // Excepting instructions never touch memory.
   assign w_need_mem = r_valid_p0 & (w_load_op | w_mem_we) & ~w_ex;
   assign w_req      = (w_idle & w_need_mem & ~w_flush) | w_wait | w_drain;
   assign w_ready_go = ~w_need_mem | w_acpt | ((w_idle | w_wait) & w_addr_ok);
   assign w_allowin  = ~w_drain & (~r_valid_p0 | (w_ready_go & m1_if.m2s_allowin));
   assign w_discard  = (w_wait & w_addr_ok & w_flush) | (w_acpt & w_flush)
                     | (w_drain & w_addr_ok);
   // An outstanding, not yet accepted request keeps its fields stable across a flush.
   assign w_hold_bus = w_drain | (w_wait & ~w_addr_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid_p0 <= 1'b0;
         r_bus_p0   <= '0;
         r_state    <= S_IDLE;
      end else begin
         if (w_flush)
            r_valid_p0 <= 1'b0;
         else if (w_allowin)
            r_valid_p0 <= m1_if.es_to_m1s_valid;

         if (w_flush) begin
            if (!w_hold_bus)
               r_bus_p0 <= '0;
         end else if (m1_if.es_to_m1s_valid && w_allowin) begin
            r_bus_p0 <= m1_if.es_to_m1s_bus;
         end

         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (!w_addr_ok)
                     r_state <= S_WAIT;
                  else if (!m1_if.m2s_allowin)
                     r_state <= S_ACPT;
               end
            end
            S_WAIT: begin
               if (w_addr_ok)
                  r_state <= (w_flush || m1_if.m2s_allowin) ? S_IDLE : S_ACPT;
               else if (w_flush)
                  r_state <= S_DRAIN;
            end
            S_ACPT: begin
               if (w_flush || m1_if.m2s_allowin)
                  r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (w_addr_ok)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m1_if.m1s_allowin      = w_allowin;
   assign m1_if.m1s_to_m2s_valid = r_valid_p0 & w_ready_go & ~w_flush;
   assign m1_if.m1s_to_m2s_bus   = {w_need_mem, r_bus_p0};

   assign m1_if.data_req   = w_req;
   assign m1_if.data_wr    = w_mem_we;
   assign m1_if.data_wstrb = w_mem_we ? r_bus_p0[142:139] : 4'b0000;
   assign m1_if.data_wdata = r_bus_p0[174:143];
   assign m1_if.data_size  = (w_mem_inst[2] | w_mem_inst[3] | w_mem_inst[8]) ? 2'd0 :
                             (w_mem_inst[4] | w_mem_inst[5] | w_mem_inst[9]) ? 2'd1 : 2'd2;
   // Unaligned lwl/lwr/swl/swr fetch the enclosing aligned word.
   assign m1_if.data_addr  = {w_alu_result[31:2],
                              (w_mem_inst[6] | w_mem_inst[7] | w_mem_inst[10] | w_mem_inst[11])
                                 ? 2'b00 : w_alu_result[1:0]};

   assign m1_if.m1s_discard   = w_discard;
   assign m1_if.M1_dest       = w_dest & {5{r_valid_p0}};
   assign m1_if.M1_result     = w_alu_result;
   assign m1_if.m1s_load_op   = r_valid_p0 & w_load_op;
   assign m1_if.m1s_inst_mfc0 = r_valid_p0 & w_mfc0;
   assign m1_if.m1s_ex        = r_valid_p0 & w_ex;
   assign m1_if.m1s_inst_eret = r_valid_p0 & w_eret;

`ifdef M1_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = w_wait | w_drain | (w_idle & w_req & ~w_addr_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign m1_if.m1s_stall_cnt = r_stall_cnt;
`else
   assign m1_if.m1s_stall_cnt = 32'd0;
`endif

endmodule
